// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// Latency: start sampled at edge N -> hi/lo/done after edge N+34 (N+2 on a skipped zero divide).
// Backpressure: busy stalls the pipe; start while busy and MTHI/MTLO while busy are dropped.
//
// Ports: clk/rst (sync, active-high), start/op/a/b launch an operation,
//        hi_we/lo_we/wdata implement MTHI/MTLO, busy/done report progress,
//        hi/lo are the architectural registers, div_zero flags a zero divisor.
// Build option MULDIV_DIVZERO_EN: adds the div_zero port and lets a divide by
// zero bypass the iteration (IDLE -> FIX). Undefined, a zero divisor runs the
// full iteration and produces the same hi/lo.
//
// The start edge only captures raw operands; the following edge (still in IDLE)
// conditions them into magnitudes and enters RUN, which keeps the two's
// complement negation off the operand input path.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIVZERO_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic             pend;      // operands captured, conditioning pending
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] b_raw;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;    // mult: running upper product; div: partial remainder
    logic [WIDTH-1:0] acc_lo;    // mult: multiplier shifting out; div: dividend in / quotient out
    logic [WIDTH-1:0] opnd;      // multiplicand or divisor magnitude
    logic             neg_lo;    // negate product / quotient
    logic             neg_hi;    // negate remainder (dividend sign)
    logic             b_zero;

    logic             is_div;
    logic             is_sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept;
    logic             launch;
    logic             mt_ok;
    logic             skip_run;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    assign is_div = op_q[1];
    assign is_sgn = ~op_q[0];
    assign a_neg  = is_sgn & a_raw[WIDTH-1];
    assign b_neg  = is_sgn & b_raw[WIDTH-1];
    assign a_mag  = a_neg ? (~a_raw + 1'b1) : a_raw;
    assign b_mag  = b_neg ? (~b_raw + 1'b1) : b_raw;

    assign accept = (state == IDLE) & ~pend & start;
    assign launch = (state == IDLE) & pend;
    assign mt_ok  = (state == IDLE) & ~pend & ~start;

`ifdef MULDIV_DIVZERO_EN
    assign skip_run = is_div & (b_raw == '0);
`else
    assign skip_run = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Iteration step
    // ------------------------------------------------------------------
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Remainder stays below the divisor, so shifted - divisor never needs more
    // than WIDTH+1 bits; the top bit is the borrow that rejects the subtract.
    assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opnd};

    // ------------------------------------------------------------------
    // Sign correction / final result
    // ------------------------------------------------------------------
    assign prod_fix = neg_lo ? (~{acc_hi, acc_lo} + 1'b1) : {acc_hi, acc_lo};

    always_comb begin
        res_hi = prod_fix[2*WIDTH-1:WIDTH];
        res_lo = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                // Quotient sign logic would flip the all-ones pattern for a
                // negative dividend, so a zero divisor is forced explicitly.
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_hi ? (~acc_hi + 1'b1) : acc_hi;
                res_lo = neg_lo ? (~acc_lo + 1'b1) : acc_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (launch) state_nx = skip_run ? FIX : RUN;
            RUN:  if (cnt == '0) state_nx = FIX;
            FIX:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            op_q     <= '0;
            a_raw    <= '0;
            b_raw    <= '0;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            b_zero   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            div_zero <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            div_zero <= 1'b0;
`endif
            if (accept) begin
                pend  <= 1'b1;
                op_q  <= op;
                a_raw <= a;
                b_raw <= b;
            end

            if (launch) begin
                pend   <= 1'b0;
                cnt    <= CW'(WIDTH-1);
                acc_hi <= '0;
                acc_lo <= is_div ? a_mag : b_mag;
                opnd   <= is_div ? b_mag : a_mag;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
                b_zero <= (b_raw == '0);
            end

            if (state == RUN) begin
                cnt <= cnt - CW'(1);
                if (is_div) begin
                    acc_hi <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                end
            end

            if (state == FIX) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
`ifdef MULDIV_DIVZERO_EN
                div_zero <= is_div & b_zero;
`endif
            end else if (mt_ok) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: reset, MULT/MULTU/DIV/DIVU
// vectors, zero divisor, MTHI/MTLO gating, start-while-busy and mid-op reset.
module tb_mul_div_unit;

`ifdef MULDIV_DIVZERO_EN
    localparam int LAT_DZ = 2;
`else
    localparam int LAT_DZ = 34;
`endif
    localparam int LAT = 34;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULDIV_DIVZERO_EN
    logic        div_zero;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] hi_k0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
`ifdef MULDIV_DIVZERO_EN
        ,
        .div_zero(div_zero)
`endif
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after
    // the cycle budget). disturb injects a start + MTHI at edge N+10.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                          input int elat, input bit edz, input bit disturb);
        int nbusy;
        int dk;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);                 // edge N
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        a     = '0;
        b     = '0;
        hi_k0 = hi;
        nbusy = 0;
        dk    = -1;
        for (int k = 1; k <= 60 && dk < 0; k++) begin
            if (disturb && k == 10) begin
                start = 1'b1;
                op    = OP_DIVU;
                a     = 32'd100;
                b     = 32'd7;
                hi_we = 1'b1;
                wdata = 32'h0000_0BAD;
            end
            @(negedge clk);             // observing after edge N+k
            start = 1'b0;
            hi_we = 1'b0;
            if (busy) nbusy++;
            if (done) dk = k;
        end
        check({tag, "_lat"}, 64'(dk), 64'(elat));
        check({tag, "_busycyc"}, 64'(nbusy), 64'(elat - 1));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
`ifdef MULDIV_DIVZERO_EN
        check({tag, "_dz"}, 64'(div_zero), 64'(edz));
`else
        if (edz) n_checks = n_checks + 0;
`endif
    endtask

    initial begin
        int ndone;
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
`ifdef MULDIV_DIVZERO_EN
        check("rst_dz", 64'(div_zero), 64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Arithmetic vectors, each launched in the done cycle of the previous one
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT, 1'b0, 1'b0);
        run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT, 1'b0, 1'b0);
        run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT, 1'b0, 1'b0);
        run_op("divu",      OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        LAT, 1'b0, 1'b0);
        run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, LAT, 1'b0, 1'b0);
        run_op("divu_zero", OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, LAT_DZ, 1'b1, 1'b0);
        run_op("div_zero_s", OP_DIV,  32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, LAT_DZ, 1'b1, 1'b0);

        // MTHI in IDLE
        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mthi_lo", 64'(lo), 64'hFFFF_FFFF);

        // MTHI + MTLO together
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_0055;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mtboth_hi", 64'(hi), 64'h55);
        check("mtboth_lo", 64'(lo), 64'h55);

        // MTHI in the start cycle is dropped; start and MTHI during busy are dropped
        hi_we = 1'b1;
        wdata = 32'h0000_DEAD;
        run_op("start_busy", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, LAT, 1'b0, 1'b1);
        check("mthi_with_start", 64'(hi_k0), 64'h55);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no_extra_done", 64'(ndone), 64'd0);

        // Reset in the middle of an operation
        hi_we = 1'b1;
        wdata = 32'h0000_0ABC;
        @(negedge clk);
        hi_we = 1'b0;
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'hFFFF_FFFF;
        b     = 32'd2;
        @(posedge clk);                 // edge N
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);     // now after edge N+19
        rst = 1'b1;
        @(negedge clk);                 // after edge N+20
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", 64'(ndone), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
